// File: rtl/collatz_param.sv
// Collatz trajectory engine: iterates N -> N/2 or 3N+1 one step per clock from a
// sampled start value, reporting step count, peak iterate and termination flags.
module collatz_param #(
    parameter int W  = 8,
    parameter int IW = 16,
    parameter int KW = 8
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic [W-1:0]  n_0,
    input  logic          soc,
    output logic          eoc,
    output logic [KW-1:0] k,
    output logic [IW-1:0] peak,
    output logic          ovf,
    output logic          sat,
    output logic          err
);
    // state | meaning
    // IDLE  | waiting for soc; previous result still visible
    // RUN   | one Collatz step per clock until a stop condition
    // DONE  | result valid; held until soc drops
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [KW-1:0] K_MAX = {KW{1'b1}};

    state_t          state_q, state_d;
    logic [IW-1:0]   n_q;
    logic [KW-1:0]   k_q;
    logic [IW-1:0]   peak_q;
    logic            ovf_q, sat_q, err_q;

    // Two guard bits so the true 3N+1 is always visible before truncation.
    logic [IW+1:0]   three_n1;
    logic            step_ovf;
    logic [IW-1:0]   n_next;
    logic            stop_err, stop_one, stop_sat, stop_ovf, stop_any;

    always_comb begin
        three_n1 = {2'b00, n_q} + {1'b0, n_q, 1'b0} + {{(IW+1){1'b0}}, 1'b1};
        step_ovf = |three_n1[IW+1:IW];
        n_next   = n_q[0] ? three_n1[IW-1:0] : (n_q >> 1);
        stop_err = (n_q == '0);
        stop_one = (n_q == {{(IW-1){1'b0}}, 1'b1});
        stop_sat = (k_q == K_MAX);
        stop_ovf = n_q[0] && step_ovf;
        stop_any = stop_err || stop_one || stop_sat || stop_ovf;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (soc)      state_d = RUN;
            RUN:     if (stop_any) state_d = DONE;
            DONE:    if (!soc)     state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        eoc  = (state_q != RUN);
        k    = k_q;
        peak = peak_q;
        ovf  = ovf_q;
        sat  = sat_q;
        err  = err_q;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            n_q    <= '0;
            k_q    <= '0;
            peak_q <= '0;
            ovf_q  <= 1'b0;
            sat_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (soc) begin
                        n_q    <= {{(IW-W){1'b0}}, n_0};
                        k_q    <= '0;
                        peak_q <= {{(IW-W){1'b0}}, n_0};
                        ovf_q  <= 1'b0;
                        sat_q  <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // Priority order keeps the three flags mutually exclusive.
                    if (stop_err)      err_q <= 1'b1;
                    else if (stop_one) ;
                    else if (stop_sat) sat_q <= 1'b1;
                    else if (stop_ovf) ovf_q <= 1'b1;
                    else begin
                        n_q <= n_next;
                        k_q <= k_q + {{(KW-1){1'b0}}, 1'b1};
                        if (n_next > peak_q) peak_q <= n_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_collatz_param.sv
// Directed bench for collatz_param: default, narrow-iterate and narrow-counter
// instances driven from a vector table plus a mid-run reset sequence.
module tb_collatz_param;
    logic        clock = 1'b0;
    logic        reset_ = 1'b0;
    logic [7:0]  n_0 = '0;
    logic [2:0]  soc = '0;

    logic        eoc0, eoc1, eoc2;
    logic [7:0]  k0, k1;
    logic [3:0]  k2;
    logic [15:0] peak0, peak2;
    logic [7:0]  peak1;
    logic        ovf0, sat0, err0, ovf1, sat1, err1, ovf2, sat2, err2;

    always #5 clock = ~clock;

    collatz_param dut0 (
        .clock(clock), .reset_(reset_), .n_0(n_0), .soc(soc[0]), .eoc(eoc0),
        .k(k0), .peak(peak0), .ovf(ovf0), .sat(sat0), .err(err0)
    );
    collatz_param #(.W(7), .IW(8), .KW(8)) dut1 (
        .clock(clock), .reset_(reset_), .n_0(n_0[6:0]), .soc(soc[1]), .eoc(eoc1),
        .k(k1), .peak(peak1), .ovf(ovf1), .sat(sat1), .err(err1)
    );
    collatz_param #(.W(8), .IW(16), .KW(4)) dut2 (
        .clock(clock), .reset_(reset_), .n_0(n_0), .soc(soc[2]), .eoc(eoc2),
        .k(k2), .peak(peak2), .ovf(ovf2), .sat(sat2), .err(err2)
    );

    int cur_sel = 0;
    int c_eoc, c_k, c_peak, c_ovf, c_sat, c_err;
    always_comb begin
        c_eoc = eoc0; c_k = int'(k0); c_peak = int'(peak0);
        c_ovf = ovf0; c_sat = sat0; c_err = err0;
        if (cur_sel == 1) begin
            c_eoc = eoc1; c_k = int'(k1); c_peak = int'(peak1);
            c_ovf = ovf1; c_sat = sat1; c_err = err1;
        end else if (cur_sel == 2) begin
            c_eoc = eoc2; c_k = int'(k2); c_peak = int'(peak2);
            c_ovf = ovf2; c_sat = sat2; c_err = err2;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int sel; int n0; int exp_k; int exp_peak;
        int exp_ovf; int exp_sat; int exp_err; int exp_edges;
    } vec_t;
    vec_t vecs[7];

    // Start a run with soc held, count edges until eoc rises, check the result.
    task automatic run_vec(input vec_t v);
        int edges;
        cur_sel = v.sel;
        @(negedge clock);
        n_0 = 8'(v.n0);
        soc[v.sel] = 1'b1;
        @(posedge clock); #1;
        check($sformatf("busy n0=%0d", v.n0), c_eoc, 0);
        n_0 = 8'h55;
        edges = 0;
        while (!c_eoc && edges < 400) begin
            @(posedge clock); #1;
            edges++;
        end
        check($sformatf("eoc edges n0=%0d", v.n0), edges, v.exp_edges);
        check($sformatf("k n0=%0d", v.n0), c_k, v.exp_k);
        check($sformatf("peak n0=%0d", v.n0), c_peak, v.exp_peak);
        check($sformatf("ovf n0=%0d", v.n0), c_ovf, v.exp_ovf);
        check($sformatf("sat n0=%0d", v.n0), c_sat, v.exp_sat);
        check($sformatf("err n0=%0d", v.n0), c_err, v.exp_err);
        check($sformatf("flags onehot n0=%0d", v.n0), int'(c_ovf + c_sat + c_err <= 1), 1);
        @(posedge clock); #1;
        check($sformatf("done hold eoc n0=%0d", v.n0), c_eoc, 1);
        check($sformatf("done hold k n0=%0d", v.n0), c_k, v.exp_k);
        @(negedge clock);
        soc[v.sel] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check($sformatf("idle eoc n0=%0d", v.n0), c_eoc, 1);
        check($sformatf("idle k n0=%0d", v.n0), c_k, v.exp_k);
        check($sformatf("idle peak n0=%0d", v.n0), c_peak, v.exp_peak);
    endtask

    initial begin
        vecs[0] = '{0,   6,   8,   16, 0, 0, 0,   9};
        vecs[1] = '{0,  27, 111, 9232, 0, 0, 0, 112};
        vecs[2] = '{1,  27,  11,  214, 1, 0, 0,  12};
        vecs[3] = '{2,   7,  15,   52, 0, 1, 0,  16};
        vecs[4] = '{0,   1,   0,    1, 0, 0, 0,   1};
        vecs[5] = '{0,   0,   0,    0, 0, 0, 1,   1};
        vecs[6] = '{1,   3,   7,   16, 0, 0, 0,   8};

        #12;
        check("reset eoc", eoc0, 1);
        check("reset k", int'(k0), 0);
        check("reset peak", int'(peak0), 0);
        check("reset flags", int'({ovf0, sat0, err0}), 0);
        @(negedge clock);
        reset_ = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a long run, then restart straight away.
        cur_sel = 0;
        @(negedge clock);
        n_0 = 8'd27;
        soc[0] = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("midrun busy", c_eoc, 0);
        check("midrun k", c_k, 19);
        #2;
        reset_ = 1'b0;
        #1;
        check("async reset eoc", c_eoc, 1);
        check("async reset k", c_k, 0);
        check("async reset peak", c_peak, 0);
        soc[0] = 1'b0;
        @(negedge clock);
        reset_ = 1'b1;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
